// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product datapath: state encoding,
// default widths/latency and a constant-foldable clog2.
package dp_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam int DEF_PIXEL_N     = 10;
  localparam int DEF_PIXEL_SIZE  = 10;
  localparam int DEF_WEIGHT_SIZE = 19;
  localparam int DEF_VAL_SIZE    = 26;
  localparam int FPM_DELAY       = 4;
  localparam int FPA_DELAY       = 4;
  // Bus fill plus multiplier and adder-tree pipelines plus two boundary registers.
  localparam int DEF_DP_LATENCY  = DEF_PIXEL_N + FPM_DELAY + FPA_DELAY + 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dp_latency_timer.sv
// Load/decrement counter; done strobes in the cycle the count is 1,
// i.e. the last cycle before it reaches 0.
module dp_latency_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/dp_operand_loader.sv
// Collects (pixel, weight) pairs into the flat operand buses of the
// dot-product unit, starts it, waits its fixed latency and returns the result.
module dp_operand_loader
  import dp_pkg::*;
#(
  parameter int PIXEL_N     = DEF_PIXEL_N,
  parameter int PIXEL_SIZE  = DEF_PIXEL_SIZE,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter int VAL_SIZE    = DEF_VAL_SIZE,
  parameter int DP_LATENCY  = DEF_DP_LATENCY
) (
  input  logic                            clk,
  input  logic                            GlobalReset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PIXEL_SIZE-1:0]           in_pixel,
  input  logic [WEIGHT_SIZE-1:0]          in_weight,
  input  logic                            in_last,
  output logic [PIXEL_N*PIXEL_SIZE-1:0]   Pixels,
  output logic [PIXEL_N*WEIGHT_SIZE-1:0]  Weights,
  output logic                            dp_start,
  input  logic [VAL_SIZE-1:0]             dp_value,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [VAL_SIZE-1:0]             out_value,
  output logic                            busy
);

  localparam int IDX_W = clog2(PIXEL_N + 1);
  localparam int CNT_W = clog2(DP_LATENCY + 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             frame_end;
  logic             timer_done;
  logic             capture;
  logic             consume;

  // Handshake decoded from the state register only, so in_ready never
  // depends combinationally on in_valid.
  assign in_ready  = (state == FILL);
  assign busy      = ~in_ready;
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && (in_last || (idx == IDX_W'(PIXEL_N - 1)));
  assign capture   = (state == COMPUTE) && timer_done;
  assign consume   = (state == OUTPUT) && out_valid && out_ready;

  dp_latency_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .load       (frame_end),
    .load_value (CNT_W'(DP_LATENCY)),
    .done       (timer_done)
  );

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (frame_end) state_next = COMPUTE;
      COMPUTE: if (capture)   state_next = OUTPUT;
      OUTPUT:  if (consume)   state_next = FILL;
      default:                state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      idx       <= '0;
      Pixels    <= '0;
      Weights   <= '0;
      dp_start  <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
    end else begin
      dp_start <= frame_end;
      if (accept) begin
        Pixels[int'(idx)*PIXEL_SIZE +: PIXEL_SIZE]   <= in_pixel;
        Weights[int'(idx)*WEIGHT_SIZE +: WEIGHT_SIZE] <= in_weight;
        idx <= idx + IDX_W'(1);
      end
      if (capture) begin
        out_value <= dp_value;
        out_valid <= 1'b1;
      end
      // Clearing the buses keeps unwritten slots of a short frame at zero.
      if (consume) begin
        out_valid <= 1'b0;
        idx       <= '0;
        Pixels    <= '0;
        Weights   <= '0;
      end
    end
  end

endmodule
